// File: rtl/btn_debounce_pkg.sv
// Shared types, limits and helpers for the multi-channel button debouncer.
// Optional auto-repeat is enabled by defining BTN_DEBOUNCE_AUTOREPEAT_EN.
package btn_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } deb_state_t;

   localparam int MIN_DEBOUNCE_CYCLES     = 2;
   localparam int MIN_SYNC_STAGES         = 2;
   localparam int MIN_REPEAT_DELAY_CYCLES = 1;
   localparam int MIN_REPEAT_RATE_CYCLES  = 1;

   function automatic int us_to_cycles(input int clk_rate, input int us);
      return (clk_rate / 1000000) * us;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounce channel: synchroniser, qualification FSM, registered level/pulses.
// Auto-repeat counter is present only when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module btn_debounce_chan
   import btn_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = 8,
   parameter int SYNC_STAGES         = 2,
   parameter int REPEAT_DELAY_CYCLES = 40,
   parameter int REPEAT_RATE_CYCLES  = 16
) (
   input  logic clock,
   input  logic rst,
   input  logic btn,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_debounce
      $error("btn_debounce_chan: debounce time must be at least %0d cycles", MIN_DEBOUNCE_CYCLES);
   end
   if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
      $error("btn_debounce_chan: synchroniser needs at least %0d stages", MIN_SYNC_STAGES);
   end
   if (REPEAT_DELAY_CYCLES < MIN_REPEAT_DELAY_CYCLES) begin : g_bad_rep_delay
      $error("btn_debounce_chan: repeat delay must be at least %0d cycle", MIN_REPEAT_DELAY_CYCLES);
   end
   if (REPEAT_RATE_CYCLES < MIN_REPEAT_RATE_CYCLES) begin : g_bad_rep_rate
      $error("btn_debounce_chan: repeat rate must be at least %0d cycle", MIN_REPEAT_RATE_CYCLES);
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   deb_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      if (rst) begin
         sync_q  <= '0;
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any disagreement of s during a WAIT state abandons qualification;
   // re-entering WAIT always restarts the count from zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE_LOW: begin
            if (s) begin
               state_d = WAIT_HIGH;
               cnt_d   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!s) begin
               state_d = IDLE_LOW;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE_HIGH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IDLE_HIGH: begin
            if (!s) begin
               state_d = WAIT_LOW;
               cnt_d   = '0;
            end
         end
         WAIT_LOW: begin
            if (s) begin
               state_d = IDLE_HIGH;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE_LOW;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign level_d = (state_q == IDLE_HIGH) || (state_q == WAIT_LOW);

   // Pulses come from edges of the registered level, so they align with it.
   always_ff @(posedge clock) begin
      if (rst) begin
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         btn_level     <= level_d;
         press_pulse   <= level_d & ~btn_level;
         release_pulse <= ~level_d & btn_level;
      end
   end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   localparam int REP_MAX = max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_cnt_q;
   logic             rep_first_done_q;
   logic             rep_fire;

   assign rep_fire = (state_q == IDLE_HIGH) &&
                     (rep_first_done_q ? (rep_cnt_q == REP_W'(REPEAT_RATE_CYCLES))
                                       : (rep_cnt_q == REP_W'(REPEAT_DELAY_CYCLES)));

   // rep_cnt counts cycles spent in IDLE_HIGH; it restarts at one after each fire.
   always_ff @(posedge clock) begin
      if (rst || (state_q != IDLE_HIGH)) begin
         rep_cnt_q        <= '0;
         rep_first_done_q <= 1'b0;
         repeat_pulse     <= 1'b0;
      end else if (rep_fire) begin
         rep_cnt_q        <= REP_W'(1);
         rep_first_done_q <= 1'b1;
         repeat_pulse     <= 1'b1;
      end else begin
         rep_cnt_q        <= rep_cnt_q + 1'b1;
         repeat_pulse     <= 1'b0;
      end
   end
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel debouncer top: NUM_BTNS independent btn_debounce_chan instances.
// Auto-repeat is compiled in when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module btn_debounce_multi
   import btn_debounce_pkg::*;
#(
   parameter int CLK_RATE        = 100000000,
   parameter int NUM_BTNS        = 4,
   parameter int DEBOUNCE_US     = 10000,
   parameter int SYNC_STAGES     = 2,
   parameter int REPEAT_DELAY_US = 500000,
   parameter int REPEAT_RATE_US  = 100000
) (
   input  logic                clock,
   input  logic                rst,
   input  logic [NUM_BTNS-1:0] btn,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] press_pulse,
   output logic [NUM_BTNS-1:0] release_pulse,
   output logic [NUM_BTNS-1:0] repeat_pulse
);

   localparam int D_CYCLES  = us_to_cycles(CLK_RATE, DEBOUNCE_US);
   localparam int R0_CYCLES = us_to_cycles(CLK_RATE, REPEAT_DELAY_US);
   localparam int R1_CYCLES = us_to_cycles(CLK_RATE, REPEAT_RATE_US);

   if (NUM_BTNS < 1) begin : g_bad_num
      $error("btn_debounce_multi: NUM_BTNS must be at least 1");
   end

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
      btn_debounce_chan #(
         .DEBOUNCE_CYCLES     (D_CYCLES),
         .SYNC_STAGES         (SYNC_STAGES),
         .REPEAT_DELAY_CYCLES (R0_CYCLES),
         .REPEAT_RATE_CYCLES  (R1_CYCLES)
      ) u_chan (
         .clock         (clock),
         .rst           (rst),
         .btn           (btn[i]),
         .btn_level     (btn_level[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .repeat_pulse  (repeat_pulse[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed self-checking bench for btn_debounce_multi (D=8, 2 sync stages).
// Repeat expectations follow BTN_DEBOUNCE_AUTOREPEAT_EN.
module tb_btn_debounce_multi;

   localparam int NB = 4;

   logic          clock = 1'b0;
   logic          rst;
   logic [NB-1:0] btn;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] press_pulse;
   logic [NB-1:0] release_pulse;
   logic [NB-1:0] repeat_pulse;

   int tests_run    = 0;
   int tests_failed = 0;
   int press_seen;
   int release_seen;

   always #5 clock = ~clock;

   btn_debounce_multi #(
      .CLK_RATE        (1000000),
      .NUM_BTNS        (NB),
      .DEBOUNCE_US     (8),
      .SYNC_STAGES     (2),
      .REPEAT_DELAY_US (40),
      .REPEAT_RATE_US  (16)
   ) dut (
      .clock         (clock),
      .rst           (rst),
      .btn           (btn),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   // One tick passes a rising edge and lands 1 time unit after it.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [NB-1:0] b, input logic r);
      btn = b;
      rst = r;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset
      applyStimulus(4'b0000, 1'b1);
      tick(3);
      checkOutput("reset_level", 32'(btn_level), 32'h0);
      checkOutput("reset_press", 32'(press_pulse), 32'h0);
      checkOutput("reset_release", 32'(release_pulse), 32'h0);
      applyStimulus(4'b0000, 1'b0);
      tick(2);

      // Clean press on btn[0]
      applyStimulus(4'b0001, 1'b0);
      tick(11);
      checkOutput("press0_early_level", 32'(btn_level), 32'h0);
      checkOutput("press0_early_press", 32'(press_pulse), 32'h0);
      tick(1);
      checkOutput("press0_level", 32'(btn_level), 32'h1);
      checkOutput("press0_pulse", 32'(press_pulse), 32'h1);
      tick(1);
      checkOutput("press0_pulse_width", 32'(press_pulse), 32'h0);
      checkOutput("press0_level_hold", 32'(btn_level), 32'h1);

      // Release with a glitch back high
      tick(38);
      applyStimulus(4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         checkOutput("glitch_level_low_phase", 32'(btn_level), 32'h1);
      end
      applyStimulus(4'b0001, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         checkOutput("glitch_level_high_phase", 32'(btn_level), 32'h1);
         checkOutput("glitch_no_release", 32'(release_pulse), 32'h0);
      end
      applyStimulus(4'b0000, 1'b0);
      press_seen = 0;
      for (int i = 0; i < 11; i++) begin
         tick(1);
         if (press_pulse[0]) press_seen++;
         checkOutput("release_wait_level", 32'(btn_level), 32'h1);
      end
      checkOutput("glitch_no_press", 32'(press_seen), 32'h0);
      tick(1);
      checkOutput("release0_level", 32'(btn_level), 32'h0);
      checkOutput("release0_pulse", 32'(release_pulse), 32'h1);
      tick(1);
      checkOutput("release0_pulse_width", 32'(release_pulse), 32'h0);
      tick(10);

      // Bounce on btn[1]
      press_seen   = 0;
      release_seen = 0;
      for (int i = 0; i < 30; i++) begin
         applyStimulus({2'b00, ((i / 3) % 2 == 0), 1'b0}, 1'b0);
         tick(1);
         if (press_pulse[1]) press_seen++;
         if (release_pulse[1]) release_seen++;
      end
      checkOutput("bounce_level_low", 32'(btn_level), 32'h0);
      applyStimulus(4'b0010, 1'b0);
      for (int i = 0; i < 11; i++) begin
         tick(1);
         if (press_pulse[1]) press_seen++;
      end
      checkOutput("bounce_early_press", 32'(press_seen), 32'h0);
      tick(1);
      checkOutput("bounce_press1", 32'(press_pulse), 32'h2);
      press_seen = 1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (press_pulse[1]) press_seen++;
         if (release_pulse[1]) release_seen++;
      end
      checkOutput("bounce_press_count", 32'(press_seen), 32'h1);
      checkOutput("bounce_release_count", 32'(release_seen), 32'h0);
      applyStimulus(4'b0000, 1'b0);
      tick(30);
      checkOutput("settled_low", 32'(btn_level), 32'h0);

      // Simultaneous press on all channels
      applyStimulus(4'b1111, 1'b0);
      tick(11);
      checkOutput("simul_early", 32'(press_pulse), 32'h0);
      tick(1);
      checkOutput("simul_press", 32'(press_pulse), 32'hF);
      checkOutput("simul_level", 32'(btn_level), 32'hF);
      tick(1);
      checkOutput("simul_width", 32'(press_pulse), 32'h0);
      tick(5);

      // Reset while btn[2] held and level high
      checkOutput("pre_reset_level2", 32'(btn_level[2]), 32'h1);
      applyStimulus(4'b0100, 1'b1);
      tick(1);
      checkOutput("rst_level", 32'(btn_level), 32'h0);
      checkOutput("rst_press", 32'(press_pulse), 32'h0);
      checkOutput("rst_release", 32'(release_pulse), 32'h0);
      tick(2);
      checkOutput("rst_release_hold", 32'(release_pulse), 32'h0);
      applyStimulus(4'b0100, 1'b0);
      release_seen = 0;
      for (int i = 0; i < 11; i++) begin
         tick(1);
         if (release_pulse != '0) release_seen++;
      end
      checkOutput("post_rst_early_press", 32'(press_pulse), 32'h0);
      checkOutput("post_rst_no_release", 32'(release_seen), 32'h0);
      tick(1);
      checkOutput("post_rst_press2", 32'(press_pulse), 32'h4);
      checkOutput("post_rst_level2", 32'(btn_level), 32'h4);
      applyStimulus(4'b0000, 1'b0);
      tick(30);

      // Auto-repeat on btn[0], held 100 cycles
      applyStimulus(4'b0001, 1'b0);
      tick(12);
      checkOutput("rep_press0", 32'(press_pulse), 32'h1);
      checkOutput("rep_at_press", 32'(repeat_pulse), 32'h0);
      for (int k = 1; k <= 89; k++) begin
         logic exp_rep;
         tick(1);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
         exp_rep = (k == 40) || (k == 56) || (k == 72) || (k == 88);
`else
         exp_rep = 1'b0;
`endif
         checkOutput($sformatf("repeat0_k%0d", k), 32'(repeat_pulse), {31'd0, exp_rep});
      end
      applyStimulus(4'b0000, 1'b0);
      tick(15);
      checkOutput("rep_final_level", 32'(btn_level), 32'h0);
      checkOutput("rep_final_repeat", 32'(repeat_pulse), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
